// File: rtl/au4_ptr_ctrl.sv
// AU-4 pointer controller for the STM-1 transmit path: frame position, per-frame
// justification/NDF decision, pointer word generation and row-4 H-byte stream.
module au4_ptr_ctrl #(
    parameter logic [9:0] PTR_RST     = 10'd522,
    parameter int         HOLD_FRAMES = 3
) (
    input  logic       clk19,
    input  logic       rst,
    input  logic       txsof,
    input  logic       inc_req,
    input  logic       dec_req,
    input  logic [9:0] cfg_ptr,
    input  logic       cfg_load,
    output logic       ptr_en,
    output logic [7:0] ptr_dat,
    output logic       neg_opp,
    output logic       pos_stuff,
    output logic [9:0] cur_ptr,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        D_NORMAL = 2'd0,
        D_INC    = 2'd1,
        D_DEC    = 2'd2,
        D_NDF    = 2'd3
    } dec_t;

    localparam logic [11:0] POS_LAST = 12'd2429;
    localparam logic [11:0] POS_H1   = 12'd810;
    localparam logic [11:0] POS_CMT  = 12'd818;
    localparam logic [9:0]  PTR_MAX  = 10'd782;
    localparam logic [9:0]  I_MASK   = 10'b10_1010_1010;
    localparam logic [9:0]  D_MASK   = 10'b01_0101_0101;
    localparam logic [2:0]  HOLD_VAL = 3'(HOLD_FRAMES);

    function automatic logic [15:0] ptr_word(input dec_t d, input logic [9:0] p);
        logic [15:0] w;
        case (d)
            D_INC:   w = {4'b0110, 2'b10, p ^ I_MASK};
            D_DEC:   w = {4'b0110, 2'b10, p ^ D_MASK};
            D_NDF:   w = {4'b1001, 2'b10, p};
            default: w = {4'b0110, 2'b10, p};
        endcase
        return w;
    endfunction

    function automatic logic [9:0] ptr_up(input logic [9:0] p);
        return (p == PTR_MAX) ? 10'd0 : p + 10'd1;
    endfunction

    function automatic logic [9:0] ptr_down(input logic [9:0] p);
        return (p == 10'd0) ? PTR_MAX : p - 10'd1;
    endfunction

    logic [11:0] pos_r, pos_nxt;
    dec_t        dec_r, dec_nxt;
    logic [2:0]  hold_r, hold_nxt;
    logic [9:0]  ptr_r, ptr_nxt;
    logic        load_pend_r, load_pend_nxt;
    logic [9:0]  load_val_r, load_val_nxt;
    logic        en_nxt, neg_nxt, stuff_nxt, err_nxt;
    logic [7:0]  dat_nxt;
    logic [15:0] word;
    logic        cfg_ok;

    assign word    = ptr_word(dec_r, ptr_r);
    assign cfg_ok  = cfg_load && (cfg_ptr <= PTR_MAX);
    assign cur_ptr = ptr_r;

    // Next-state: position, frame decision, pointer commit, pending load and outputs.
    // All registered outputs are computed from pos_nxt so they line up with pos.
    always_comb begin
        dec_nxt       = dec_r;
        hold_nxt      = hold_r;
        ptr_nxt       = ptr_r;
        load_pend_nxt = load_pend_r;
        load_val_nxt  = load_val_r;
        en_nxt        = 1'b0;
        dat_nxt       = 8'h00;
        neg_nxt       = 1'b0;
        stuff_nxt     = 1'b0;
        err_nxt       = cfg_load && !cfg_ok;

        if (txsof) begin
            pos_nxt = 12'd0;
        end else if (pos_r == POS_LAST) begin
            pos_nxt = 12'd0;
        end else begin
            pos_nxt = pos_r + 12'd1;
        end

        if (pos_nxt == 12'd0) begin
            if (load_pend_r) begin
                dec_nxt       = D_NDF;
                hold_nxt      = HOLD_VAL;
                ptr_nxt       = load_val_r;
                load_pend_nxt = 1'b0;
            end else if (hold_r != 3'd0) begin
                dec_nxt  = D_NORMAL;
                hold_nxt = hold_r - 3'd1;
            end else if (inc_req && !dec_req) begin
                dec_nxt  = D_INC;
                hold_nxt = HOLD_VAL;
            end else if (dec_req && !inc_req) begin
                dec_nxt  = D_DEC;
                hold_nxt = HOLD_VAL;
            end else begin
                dec_nxt = D_NORMAL;
            end
        end else if (pos_nxt == POS_CMT) begin
            // A forced restart before this point never reaches the commit
            case (dec_r)
                D_INC:   ptr_nxt = ptr_up(ptr_r);
                D_DEC:   ptr_nxt = ptr_down(ptr_r);
                default: ptr_nxt = ptr_r;
            endcase
        end else begin
            ptr_nxt = ptr_r;
        end

        // A new load after the frame-start clear wins over it
        if (cfg_ok) begin
            load_pend_nxt = 1'b1;
            load_val_nxt  = cfg_ptr;
        end else begin
            load_val_nxt = load_val_r;
        end

        case (pos_nxt)
            POS_H1: begin
                en_nxt  = 1'b1;
                dat_nxt = word[15:8];
            end
            12'd811, 12'd812: begin
                en_nxt  = 1'b1;
                dat_nxt = 8'h9B;
            end
            12'd813: begin
                en_nxt  = 1'b1;
                dat_nxt = word[7:0];
            end
            12'd814, 12'd815: begin
                en_nxt  = 1'b1;
                dat_nxt = 8'hFF;
            end
            12'd816, 12'd817, 12'd818: begin
                if (dec_r == D_DEC) begin
                    neg_nxt = 1'b1;
                end else begin
                    en_nxt = 1'b1;
                end
            end
            12'd819, 12'd820, 12'd821: begin
                if (dec_r == D_INC) begin
                    en_nxt    = 1'b1;
                    stuff_nxt = 1'b1;
                end else begin
                    en_nxt = 1'b0;
                end
            end
            default: en_nxt = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk19) begin
        if (rst) begin
            pos_r       <= 12'd0;
            dec_r       <= D_NORMAL;
            hold_r      <= 3'd0;
            ptr_r       <= PTR_RST;
            load_pend_r <= 1'b0;
            load_val_r  <= 10'd0;
            ptr_en      <= 1'b0;
            ptr_dat     <= 8'h00;
            neg_opp     <= 1'b0;
            pos_stuff   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            pos_r       <= pos_nxt;
            dec_r       <= dec_nxt;
            hold_r      <= hold_nxt;
            ptr_r       <= ptr_nxt;
            load_pend_r <= load_pend_nxt;
            load_val_r  <= load_val_nxt;
            ptr_en      <= en_nxt;
            ptr_dat     <= dat_nxt;
            neg_opp     <= neg_nxt;
            pos_stuff   <= stuff_nxt;
            cfg_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_au4_ptr_ctrl.sv
// Directed bench for au4_ptr_ctrl: frames are restarted with txsof just after the
// overhead region; pos 0 is the cycle after the txsof pulse.
module tb_au4_ptr_ctrl;

    localparam int K_NORM = 0;
    localparam int K_INC  = 1;
    localparam int K_DEC  = 2;

    logic       clk19 = 1'b0;
    logic       rst;
    logic       txsof;
    logic       inc_req;
    logic       dec_req;
    logic [9:0] cfg_ptr;
    logic       cfg_load;
    logic       ptr_en;
    logic [7:0] ptr_dat;
    logic       neg_opp;
    logic       pos_stuff;
    logic [9:0] cur_ptr;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;
    int bpos     = 0;
    int fnum     = 0;

    au4_ptr_ctrl dut (
        .clk19    (clk19),
        .rst      (rst),
        .txsof    (txsof),
        .inc_req  (inc_req),
        .dec_req  (dec_req),
        .cfg_ptr  (cfg_ptr),
        .cfg_load (cfg_load),
        .ptr_en   (ptr_en),
        .ptr_dat  (ptr_dat),
        .neg_opp  (neg_opp),
        .pos_stuff(pos_stuff),
        .cur_ptr  (cur_ptr),
        .cfg_err  (cfg_err)
    );

    always #5 clk19 = ~clk19;

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs != exp) begin
            failures = failures + 1;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk19);
        #1;
        bpos = bpos + 1;
    endtask

    // Packs {ptr_en, neg_opp, pos_stuff, ptr_dat} expected at a given position.
    function automatic int exp_ovh(input int p, input int h1, input int h2, input int kind);
        int v;
        case (p)
            810:           v = 'h400 | h1;
            811, 812:      v = 'h400 | 'h9B;
            813:           v = 'h400 | h2;
            814, 815:      v = 'h400 | 'hFF;
            816, 817, 818: v = (kind == K_DEC) ? 'h200 : 'h400;
            819, 820, 821: v = (kind == K_INC) ? 'h500 : 'h000;
            default:       v = 'h000;
        endcase
        return v;
    endfunction

    task automatic run_frame(input int h1, input int h2, input int kind,
                             input int pb, input int pa, input int cut);
        txsof = 1'b1;
        step();
        txsof = 1'b0;
        bpos  = 0;
        fnum  = fnum + 1;
        while (bpos < cut) begin
            if (bpos >= 809) begin
                chk($sformatf("ovh_f%0d_p%0d", fnum, bpos),
                    int'({ptr_en, neg_opp, pos_stuff, ptr_dat}), exp_ovh(bpos, h1, h2, kind));
                chk($sformatf("cur_f%0d_p%0d", fnum, bpos),
                    int'(cur_ptr), (bpos >= 818) ? pa : pb);
            end
            step();
        end
    endtask

    task automatic sw_load(input int val, input int exp_err);
        cfg_ptr  = 10'(val);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        chk($sformatf("cfg_err_v%0d", val), int'(cfg_err), exp_err);
        step();
        chk($sformatf("cfg_err_clr_v%0d", val), int'(cfg_err), 0);
    endtask

    initial begin
        rst      = 1'b1;
        txsof    = 1'b0;
        inc_req  = 1'b0;
        dec_req  = 1'b0;
        cfg_ptr  = 10'd0;
        cfg_load = 1'b0;
        repeat (3) step();
        chk("rst_ovh", int'({ptr_en, neg_opp, pos_stuff, ptr_dat}), 0);
        chk("rst_cur", int'(cur_ptr), 522);
        chk("rst_err", int'(cfg_err), 0);
        rst = 1'b0;
        step();

        // Idle frames at the reset pointer
        run_frame('h6A, 'h0A, K_NORM, 522, 522, 822);
        run_frame('h6A, 'h0A, K_NORM, 522, 522, 822);

        // Positive justification, then holdoff; software load during holdoff
        inc_req = 1'b1;
        run_frame('h68, 'hA0, K_INC, 522, 523, 822);
        run_frame('h6A, 'h0B, K_NORM, 523, 523, 822);
        sw_load(100, 0);
        run_frame('h98, 'h64, K_NORM, 100, 100, 822);
        repeat (3) run_frame('h68, 'h64, K_NORM, 100, 100, 822);
        run_frame('h6A, 'hCE, K_INC, 100, 101, 822);
        inc_req = 1'b0;
        sw_load(800, 1);
        repeat (3) run_frame('h68, 'h65, K_NORM, 101, 101, 822);

        // Load pointer 0 then negative justification wraps to 782
        sw_load(0, 0);
        dec_req = 1'b1;
        run_frame('h98, 'h00, K_NORM, 0, 0, 822);
        repeat (3) run_frame('h68, 'h00, K_NORM, 0, 0, 822);
        run_frame('h69, 'h55, K_DEC, 0, 782, 822);

        // Both requests high: never acts
        inc_req = 1'b1;
        repeat (5) run_frame('h6B, 'h0E, K_NORM, 782, 782, 822);
        dec_req = 1'b0;

        // INC frame cut short by txsof at pos 815: no commit, holdoff continues
        run_frame('h69, 'hA4, K_INC, 782, 782, 815);
        repeat (3) run_frame('h6B, 'h0E, K_NORM, 782, 782, 822);
        run_frame('h69, 'hA4, K_INC, 782, 0, 822);

        // Pending NDF frame interrupted by reset at pos 812
        sw_load(50, 0);
        run_frame('h98, 'h32, K_NORM, 50, 50, 812);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst812_ovh", int'({ptr_en, neg_opp, pos_stuff, ptr_dat}), 0);
        chk("rst812_cur", int'(cur_ptr), 522);
        step();
        run_frame('h68, 'hA0, K_INC, 522, 523, 822);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
